// File: rtl/cv32e40p_tmr_voter_monitor.sv
// Registered TMR majority voter with per-replica outlier tracking,
// sticky permanent-fault marking and graceful degradation to two-replica
// or single-replica operation once replicas are declared faulty.
module cv32e40p_tmr_voter_monitor #(
  parameter int WIDTH       = 32,
  parameter int PERM_THRESH = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] in_1_i,
  input  logic [WIDTH-1:0] in_2_i,
  input  logic [WIDTH-1:0] in_3_i,
  input  logic             clear_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] voted_o,
  output logic             error_correct_o,
  output logic             error_detected_o,
  output logic [2:0]       outlier_o,
  output logic [2:0]       perm_fault_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int              OC_W    = $clog2(PERM_THRESH + 1);
  localparam logic [OC_W-1:0] OC_MAX  = OC_W'(PERM_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bitwise two-out-of-three majority.
  function automatic logic [WIDTH-1:0] f_majority(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Saturating increment of an outlier counter at the permanent-fault threshold.
  function automatic logic [OC_W-1:0] f_sat_inc_oc(input logic [OC_W-1:0] v);
    return (v >= OC_MAX) ? OC_MAX : v + 1'b1;
  endfunction

  // Saturating increment of the total-error counter (never wraps).
  function automatic logic [CNT_W-1:0] f_sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
  endfunction

  // Registered state
  logic             r_valid;
  logic [WIDTH-1:0] r_voted;
  logic             r_corr;
  logic             r_det;
  logic [2:0]       r_outlier;
  logic [2:0]       r_perm;
  logic [OC_W-1:0]  r_oc [3];
  logic [CNT_W-1:0] r_cnt;

  // Combinational vote
  logic [WIDTH-1:0] w_in [3];
  logic             w_eq01;
  logic             w_eq02;
  logic             w_eq12;
  logic [1:0]       w_nfault;
  logic [WIDTH-1:0] w_lowest;
  logic             w_pair_eq;
  logic [WIDTH-1:0] w_voted;
  logic             w_corr;
  logic             w_det;
  logic [2:0]       w_outlier;
  logic [OC_W-1:0]  w_oc_nxt [3];
  logic [2:0]       w_perm_nxt;

  assign w_in[0]  = in_1_i;
  assign w_in[1]  = in_2_i;
  assign w_in[2]  = in_3_i;
  assign w_eq01   = (in_1_i == in_2_i);
  assign w_eq02   = (in_1_i == in_3_i);
  assign w_eq12   = (in_2_i == in_3_i);
  assign w_nfault = {1'b0, r_perm[0]} + {1'b0, r_perm[1]} + {1'b0, r_perm[2]};

  // Lowest-index healthy replica (replica 0 if none are healthy), and whether the
  // two surviving replicas agree when exactly one has been retired.
  always_comb begin
    w_lowest  = in_1_i;
    w_pair_eq = w_eq01;
    if (!r_perm[0])      w_lowest = in_1_i;
    else if (!r_perm[1]) w_lowest = in_2_i;
    else if (!r_perm[2]) w_lowest = in_3_i;
    if (r_perm[0])      w_pair_eq = w_eq12;
    else if (r_perm[1]) w_pair_eq = w_eq02;
  end

  // Vote and classify the current words using the current (pre-clear) fault mask.
  always_comb begin
    w_voted   = f_majority(in_1_i, in_2_i, in_3_i);
    w_corr    = 1'b0;
    w_det     = 1'b0;
    w_outlier = 3'b000;
    case (w_nfault)
      2'd0: begin
        if (w_eq01 && w_eq02) begin
          w_corr = 1'b0;
        end else if (w_eq01) begin
          w_corr    = 1'b1;
          w_outlier = 3'b100;
        end else if (w_eq02) begin
          w_corr    = 1'b1;
          w_outlier = 3'b010;
        end else if (w_eq12) begin
          w_corr    = 1'b1;
          w_outlier = 3'b001;
        end else begin
          w_det = 1'b1;
        end
      end
      2'd1: begin
        w_voted = w_lowest;
        w_det   = !w_pair_eq;
      end
      default: begin
        w_voted = w_lowest;
        w_det   = 1'b1;
      end
    endcase
  end

  // Next outlier counts and fault mask; detected-error cycles and retired replicas hold.
  always_comb begin
    w_perm_nxt = r_perm;
    for (int k = 0; k < 3; k++) begin
      w_oc_nxt[k] = r_oc[k];
    end
    if (valid_i && !w_det) begin
      for (int k = 0; k < 3; k++) begin
        if (!r_perm[k]) begin
          if (w_outlier[k]) begin
            w_oc_nxt[k] = f_sat_inc_oc(r_oc[k]);
          end else if (w_in[k] == w_voted) begin
            w_oc_nxt[k] = '0;
          end
          if (w_oc_nxt[k] == OC_MAX) begin
            w_perm_nxt[k] = 1'b1;
          end
        end
      end
    end
  end

  // Fault bookkeeping state; clear overrides any increment or fault set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perm <= 3'b000;
      r_cnt  <= '0;
      for (int k = 0; k < 3; k++) begin
        r_oc[k] <= '0;
      end
    end else if (clear_i) begin
      r_perm <= 3'b000;
      r_cnt  <= '0;
      for (int k = 0; k < 3; k++) begin
        r_oc[k] <= '0;
      end
    end else begin
      r_perm <= w_perm_nxt;
      for (int k = 0; k < 3; k++) begin
        r_oc[k] <= w_oc_nxt[k];
      end
      if (valid_i && (w_corr || w_det)) begin
        r_cnt <= f_sat_inc_cnt(r_cnt);
      end
    end
  end

  // Output register: voted word holds across idle cycles, flags clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_voted   <= '0;
      r_corr    <= 1'b0;
      r_det     <= 1'b0;
      r_outlier <= 3'b000;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_voted   <= w_voted;
        r_corr    <= w_corr;
        r_det     <= w_det;
        r_outlier <= w_outlier;
      end else begin
        r_corr    <= 1'b0;
        r_det     <= 1'b0;
        r_outlier <= 3'b000;
      end
    end
  end

  assign valid_o          = r_valid;
  assign voted_o          = r_voted;
  assign error_correct_o  = r_corr;
  assign error_detected_o = r_det;
  assign outlier_o        = r_outlier;
  assign perm_fault_o     = r_perm;
  assign err_cnt_o        = r_cnt;

endmodule
